seg_scan_mux: RTL and testbench

- Downstream stage of the calculator core.
- Takes the eight active-low 7-segment patterns (seg0..seg7, bit 7 = dp) and time-multiplexes them onto one shared segment bus with one-hot active-low digit enables. This suits boards with a common-anode multiplexed 8-digit display.
- Each digit slot begins with an anti-ghosting blank interval.
- The pattern for a slot is sampled once, at slot start, so mid-slot input changes cannot glitch the display.

---
 rtl/seg_scan_mux.sv | 155 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexes eight active-low 7-segment patterns onto a shared bus with a
// blank interval at the start of each digit slot. Optional blinking via SEG_SCAN_BLINK_EN.
module seg_scan_mux #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_TERM  = 49999,
    parameter int BLANK_CYC = 16
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic       clk,
    input  logic       ac,
    input  logic       enable,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [7:0] seg4,
    input  logic [7:0] seg5,
    input  logic [7:0] seg6,
    input  logic [7:0] seg7,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [7:0] blink_mask,
`endif
    output logic [7:0] seg_out,
    output logic [7:0] dig_sel,
    output logic [2:0] digit_idx,
    output logic       frame_tick
);

    localparam logic [DIV_WIDTH-1:0] TERM  = DIV_WIDTH'(DIV_TERM);
    localparam logic [DIV_WIDTH-1:0] BLANK = DIV_WIDTH'(BLANK_CYC);
    localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);

    logic [63:0] seg_bus;
    logic [7:0]  seg_arr [8];

    assign seg_bus = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            assign seg_arr[gi] = seg_bus[gi*8 +: 8];
        end
    endgenerate

    logic [DIV_WIDTH-1:0] p_reg, p_next;
    logic [2:0]           idx_reg, idx_next;
    logic [7:0]           slot_pat_reg, slot_pat_next;
    logic [7:0]           seg_out_reg, seg_out_next;
    logic [7:0]           dig_sel_reg, dig_sel_next;
    logic [2:0]           digit_idx_reg, digit_idx_next;
    logic                 frame_tick_reg, frame_tick_next;
    logic                 frame_end;
    logic                 blank_slot;

    assign frame_end = enable && (p_reg == TERM) && (idx_reg == 3'd7);

`ifdef SEG_SCAN_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

    logic [BCW-1:0] blink_cnt_reg, blink_cnt_next;
    logic           blink_phase_reg, blink_phase_next;

    // Phase flips at the frame boundary so a whole frame is either shown or hidden.
    always_comb begin
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (!enable) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge ac) begin
        if (!ac) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    assign blank_slot = blink_phase_reg && blink_mask[idx_reg];
`else
    assign blank_slot = 1'b0;
`endif

    always_comb begin
        p_next          = p_reg;
        idx_next        = idx_reg;
        slot_pat_next   = slot_pat_reg;
        seg_out_next    = 8'hFF;
        dig_sel_next    = 8'hFF;
        digit_idx_next  = idx_reg;
        frame_tick_next = 1'b0;
        if (!enable) begin
            p_next         = '0;
            idx_next       = 3'd0;
            slot_pat_next  = seg_arr[0];
            digit_idx_next = 3'd0;
        end else begin
            if (p_reg == TERM) begin
                p_next   = '0;
                idx_next = idx_reg + 3'd1;
            end else begin
                p_next = p_reg + ONE;
            end
            // Sample once per slot; idx already points at the new slot when p is 0.
            if (p_reg == '0) begin
                slot_pat_next = seg_arr[idx_reg];
            end
            if (p_reg >= BLANK) begin
                seg_out_next = blank_slot ? 8'hFF : slot_pat_reg;
                dig_sel_next = ~(8'b1 << idx_reg);
            end
            frame_tick_next = frame_end;
        end
    end

    always_ff @(posedge clk or negedge ac) begin
        if (!ac) begin
            p_reg          <= '0;
            idx_reg        <= 3'd0;
            slot_pat_reg   <= 8'hFF;
            seg_out_reg    <= 8'hFF;
            dig_sel_reg    <= 8'hFF;
            digit_idx_reg  <= 3'd0;
            frame_tick_reg <= 1'b0;
        end else begin
            p_reg          <= p_next;
            idx_reg        <= idx_next;
            slot_pat_reg   <= slot_pat_next;
            seg_out_reg    <= seg_out_next;
            dig_sel_reg    <= dig_sel_next;
            digit_idx_reg  <= digit_idx_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign seg_out    = seg_out_reg;
    assign dig_sel    = dig_sel_reg;
    assign digit_idx  = digit_idx_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a 10-cycle slot and 2 blank cycles;
// the blink scenario runs only when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_mux;

    logic       clk;
    logic       ac;
    logic       enable;
    logic [7:0] seg [8];
    logic [7:0] seg_out;
    logic [7:0] dig_sel;
    logic [2:0] digit_idx;
    logic       frame_tick;
`ifdef SEG_SCAN_BLINK_EN
    logic [7:0] blink_mask;
`endif

    logic [7:0] pat [8];
    int         cyc;
    int         errors;
    int         checks;

    seg_scan_mux #(
        .DIV_WIDTH(16),
        .DIV_TERM (9),
        .BLANK_CYC(2)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk       (clk),
        .ac        (ac),
        .enable    (enable),
        .seg0      (seg[0]),
        .seg1      (seg[1]),
        .seg2      (seg[2]),
        .seg3      (seg[3]),
        .seg4      (seg[4]),
        .seg5      (seg[5]),
        .seg6      (seg[6]),
        .seg7      (seg[7]),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {seg_out, dig_sel, digit_idx, frame_tick} after the c-th edge since restart.
    function automatic logic [19:0] exp_vec(input int c);
        int k;
        int slot;
        int ph;
        logic [7:0] s;
        logic [7:0] d;
        logic ft;
        k    = c - 1;
        slot = (k / 10) % 8;
        ph   = k % 10;
        d    = (ph < 2) ? 8'hFF : ~(8'b1 << slot);
        s    = (ph < 2) ? 8'hFF : pat[slot];
`ifdef SEG_SCAN_BLINK_EN
        if (blink_mask[slot] && ((k / 160) % 2 == 1)) s = 8'hFF;
`endif
        ft = (c % 80 == 0);
        return {s, d, 3'(slot), ft};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {seg_out, dig_sel, digit_idx, frame_tick};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        ac = 1'b1;
        #1 ac = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg_out got=%h exp=ff", seg_out); end
        checks++;
        if (dig_sel !== 8'hFF) begin errors++; $display("FAIL reset_dig_sel got=%h exp=ff", dig_sel); end
        checks++;
        if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_digit_idx got=%0d exp=0", digit_idx); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        ac  = 1'b1;
        cyc = 0;
        $display("reset released");
    endtask

    task automatic test_scan_order();
        logic [19:0] e;
        while (cyc < 80) begin
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL scan_order cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        $display("scan order: one frame of 80 cycles checked");
    endtask

    task automatic test_frame_tick();
        logic [19:0] e;
        int pulses;
        pulses = 0;
        while (cyc < 320) begin
            step();
            if (frame_tick === 1'b1) pulses++;
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL frame_tick cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL frame_tick_count got=%0d exp=3", pulses);
        end
        $display("frame_tick: %0d pulses over 3 frames", pulses);
    endtask

    task automatic test_mid_slot_change();
        logic [19:0] e;
        while (cyc < 440) begin
            if (cyc == 355) seg[3] = 8'h99;
            if (cyc == 360) pat[3] = 8'h99;
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL mid_slot cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        checks++;
        if (seg_out !== 8'h99) begin
            errors++;
            $display("FAIL mid_slot_new got=%h exp=99", seg_out);
        end
        $display("mid-slot change: digit 3 shows %h in its next slot", seg_out);
    endtask

    task automatic test_enable_drop();
        logic [19:0] e;
        while (cyc < 455) begin
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL en_pre cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({seg_out, dig_sel, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL en_low i=%0d got=%h/%h/%b exp=ff/ff/0", i, seg_out, dig_sel, frame_tick);
            end
        end
        enable = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL en_restart cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        $display("enable drop: blanked then restarted at digit 0");
    endtask

    task automatic test_async_reset();
        logic [19:0] e;
        while (cyc < 65) begin
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL ar_pre cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        ac = 1'b0;
        #1;
        checks++;
        if ({seg_out, dig_sel, digit_idx, frame_tick} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h/%h/%0d/%b exp=ff/ff/0/0", seg_out, dig_sel, digit_idx, frame_tick);
        end
        #2 ac = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            step();
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL ar_restart cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        $display("async reset: outputs blanked without a clock edge");
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        logic [19:0] e;
        int hidden;
        hidden = 0;
        blink_mask = 8'h01;
        @(negedge clk);
        ac = 1'b0;
        #3 ac = 1'b1;
        cyc = 0;
        while (cyc < 320) begin
            step();
            if (dig_sel === 8'hFE && seg_out === 8'hFF) hidden++;
            e = exp_vec(cyc);
            checks++;
            if (obs_vec() !== e) begin
                errors++;
                $display("FAIL blink cyc=%0d got=%h exp=%h", cyc, obs_vec(), e);
            end
        end
        checks++;
        if (hidden !== 16) begin
            errors++;
            $display("FAIL blink_hidden got=%0d exp=16", hidden);
        end
        $display("blink: digit 0 hidden for %0d cycles", hidden);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        enable = 1'b1;
        pat[0] = 8'hC0; pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0;
        pat[4] = 8'h99; pat[5] = 8'h92; pat[6] = 8'h82; pat[7] = 8'h80;
        for (int i = 0; i < 8; i++) seg[i] = pat[i];
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 8'h00;
`endif
        test_reset();
        test_scan_order();
        test_frame_tick();
        test_mid_slot_change();
        test_enable_drop();
        test_async_reset();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
